dqnt_expand: RTL and testbench

//  Streaming dequantizer: inverse of the datapath rounding stage. Widens a signed

---
 rtl/dqnt_expand_pkg.sv | 13 +
 rtl/dqnt_expand_if.sv | 12 +
 rtl/dqnt_expand_lfsr.sv | 16 +
 rtl/dqnt_expand.sv | 71 +++++++
 tb/tb_dqnt_expand.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/dqnt_expand_pkg.sv
// dqnt_pkg: shared types, LFSR constants and saturation helper for dqnt_expand.
package dqnt_pkg;
   typedef enum logic {RECON_ZERO, RECON_MID} recon_e;
   localparam logic [15:0] LFSR_POLY = 16'hB400;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   function automatic logic signed [31:0] sat_to_w(input logic signed [31:0] v, input int w);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (w - 1));
      return v > hi ? hi : v < lo ? lo : v;
   endfunction
endpackage

// File: rtl/dqnt_expand_if.sv
// dqnt_expand_if: input and output valid/ready streams of the dequantizer.
interface dqnt_expand_if #(parameter int NBW_IN = 7, parameter int NBW_OUT = 10);
   logic                      in_valid;
   logic                      in_ready;
   logic signed [NBW_IN-1:0]  in_data;
   logic signed [NBW_OUT-1:0] in_offset;
   logic                      out_valid;
   logic                      out_ready;
   logic signed [NBW_OUT-1:0] out_data;
   modport master(output in_valid, in_data, in_offset, out_ready, input in_ready, out_valid, out_data);
   modport slave(input in_valid, in_data, in_offset, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/dqnt_expand_lfsr.sv
// dqnt_lfsr: 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), steps only when i_step is high.
module dqnt_lfsr
   import dqnt_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_step,
   output logic [15:0] o_state
);
   logic [15:0] r_state;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= LFSR_SEED;
      else if (i_step) r_state <= {r_state[14:0], ^(r_state & LFSR_POLY)};
   end
   assign o_state = r_state;
endmodule

// File: rtl/dqnt_expand.sv
// dqnt_expand: 2-stage streaming dequantizer with offset, saturation and clip counter.
// Define DQNT_DITHER_EN to replace the constant restored LSBs with LFSR dither.
module dqnt_expand
   import dqnt_pkg::*;
#(
   parameter int     NBW_IN     = 7,
   parameter int     NB_EXP     = 3,
   parameter recon_e RECON_MODE = RECON_ZERO,
   parameter int     NBW_CNT    = 16,
   localparam int    NBW_OUT    = NBW_IN + NB_EXP
)(
   input  logic               i_clk,
   input  logic               i_rst_n,
   dqnt_expand_if.slave       bus,
   input  logic               i_clr_cnt,
   output logic [NBW_CNT-1:0] o_sat_cnt
);
   logic                      w_s1_adv;
   logic                      w_accept;
   logic [NB_EXP-1:0]         w_lsb;
   logic signed [NBW_OUT-1:0] w_cat;
   logic signed [NBW_OUT:0]   w_bias;
   logic signed [NBW_OUT:0]   w_x1;
   logic signed [NBW_OUT+1:0] w_sum;
   logic signed [31:0]        w_sat;
   logic                      w_clip;
   logic                      r_s1_v;
   logic                      r_s2_v;
   logic signed [NBW_OUT:0]   r_x1;
   logic [NBW_OUT-1:0]        r_data;
   logic [NBW_CNT-1:0]        r_cnt;

`ifdef DQNT_DITHER_EN
   logic [15:0] w_lfsr;
   dqnt_lfsr u_lfsr (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_step(w_accept), .o_state(w_lfsr));
   assign w_lsb  = w_lfsr[NB_EXP-1:0];
   // Mode 0 recentres the uniform dither on the bin so it stays zero-mean
   assign w_bias = RECON_MODE == RECON_ZERO ? (NBW_OUT+1)'(1) << (NB_EXP - 1) : '0;
`else
   assign w_lsb  = RECON_MODE == RECON_MID ? NB_EXP'(1) << (NB_EXP - 1) : '0;
   assign w_bias = '0;
`endif

   assign w_s1_adv      = !r_s2_v || bus.out_ready;
   assign bus.in_ready  = !r_s1_v || w_s1_adv;
   assign w_accept      = bus.in_valid && bus.in_ready;
   assign w_cat         = {bus.in_data, w_lsb};
   assign w_x1          = (NBW_OUT+1)'(w_cat) - w_bias;
   assign w_sum         = (NBW_OUT+2)'(r_x1) + (NBW_OUT+2)'(bus.in_offset);
   assign w_sat         = sat_to_w(32'(w_sum), NBW_OUT);
   assign w_clip        = w_sat != 32'(w_sum);
   assign bus.out_valid = r_s2_v;
   assign bus.out_data  = r_data;
   assign o_sat_cnt     = r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1_v <= 1'b0;
         r_s2_v <= 1'b0;
         r_x1   <= '0;
         r_data <= '0;
         r_cnt  <= '0;
      end else begin
         if (bus.in_ready) r_s1_v <= bus.in_valid;
         if (w_accept) r_x1 <= w_x1;
         if (w_s1_adv) r_s2_v <= r_s1_v;
         if (w_s1_adv && r_s1_v) r_data <= w_sat[NBW_OUT-1:0];
         r_cnt <= i_clr_cnt ? '0 : (w_s1_adv && r_s1_v && w_clip && ~&r_cnt) ? r_cnt + NBW_CNT'(1) : r_cnt;
      end
   end
endmodule

// File: tb/tb_dqnt_expand.sv
// tb_dqnt_expand: table vectors plus randomized streams for mode 0 and mode 1 instances.
module tb_dqnt_expand;
   import dqnt_pkg::*;

   typedef struct {int d; int off; int e0; int e1;} vec_t;
   typedef struct {int e0; int e1;} exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic [15:0] cnt0;
   logic [2:0]  cnt1;
   int          n_vec = 0;
   int          n_err = 0;
   int          mcnt0 = 0;
   int          mcnt1 = 0;

   always #5 clk = ~clk;

   dqnt_expand_if #(.NBW_IN(7), .NBW_OUT(10)) b0 ();
   dqnt_expand_if #(.NBW_IN(7), .NBW_OUT(10)) b1 ();
   assign b1.in_valid  = b0.in_valid;
   assign b1.in_data   = b0.in_data;
   assign b1.in_offset = b0.in_offset;
   assign b1.out_ready = b0.out_ready;

   dqnt_expand #(.RECON_MODE(RECON_ZERO)) u0 (
      .i_clk(clk), .i_rst_n(rst_n), .bus(b0), .i_clr_cnt(clr), .o_sat_cnt(cnt0));
   dqnt_expand #(.RECON_MODE(RECON_MID), .NBW_CNT(3)) u1 (
      .i_clk(clk), .i_rst_n(rst_n), .bus(b1), .i_clr_cnt(clr), .o_sat_cnt(cnt1));

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int raw(input int d, input int off, input bit mid);
      return d * 8 + (mid ? 4 : 0) + off;
   endfunction

   function automatic int model(input int d, input int off, input bit mid);
      int r;
      r = raw(d, off, mid);
      return r > 511 ? 511 : r < -512 ? -512 : r;
   endfunction

   function automatic bit clips(input int d, input int off, input bit mid);
      return model(d, off, mid) != raw(d, off, mid);
   endfunction

   task automatic one(input int d, input int off, input int e0, input int e1, input string nm);
      int k;
      @(negedge clk);
      b0.in_valid = 1'b1;
      b0.in_data = 7'(d);
      b0.in_offset = 10'(off);
      b0.out_ready = 1'b1;
      @(negedge clk);
      b0.in_valid = 1'b0;
      k = 1;
      while (!b0.out_valid && k < 6) begin
         @(negedge clk);
         k++;
      end
      if (clips(d, off, 0)) mcnt0++;
      if (clips(d, off, 1) && mcnt1 < 7) mcnt1++;
      chk({nm, "_lat"}, k, 2);
      chk({nm, "_m0"}, int'(b0.out_data), e0);
      chk({nm, "_m1"}, int'(b1.out_data), e1);
      chk({nm, "_cnt0"}, int'(cnt0), mcnt0);
      chk({nm, "_cnt1"}, int'(cnt1), mcnt1);
   endtask

   task automatic stream(input int n, input bit seq, input int off);
      exp_t q[$];
      exp_t e;
      int sent = 0, got = 0, cyc = 0, cur = 0;
      bit acc = 0, stall = 0;
      int h0 = 0, h1 = 0;
      b0.in_valid = 1'b0;
      b0.in_offset = 10'(off);
      while (got < n && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (stall) begin
            chk("hold_m0", int'(b0.out_data), h0);
            chk("hold_m1", int'(b1.out_data), h1);
         end
         if (acc) b0.in_valid = 1'b0;
         acc = 0;
         if (!b0.in_valid && sent < n && $urandom_range(0, 3) != 0) begin
            cur = seq ? sent + 1 : int'($urandom_range(0, 127)) - 64;
            b0.in_valid = 1'b1;
            b0.in_data = 7'(cur);
         end
         b0.out_ready = 1'($urandom_range(0, 1));
         #1;
         if (b0.in_valid && b0.in_ready) begin
            q.push_back('{model(cur, off, 0), model(cur, off, 1)});
            sent++;
            acc = 1;
         end
         stall = 0;
         if (b0.out_valid) begin
            if (b0.out_ready) begin
               if (q.size() == 0) chk("stream_dup", 1, 0);
               else begin
                  e = q.pop_front();
                  chk("stream_m0", int'(b0.out_data), e.e0);
                  chk("stream_m1", int'(b1.out_data), e.e1);
               end
               got++;
            end else begin
               stall = 1;
               h0 = int'(b0.out_data);
               h1 = int'(b1.out_data);
            end
         end
      end
      chk("stream_count", got, n);
      @(negedge clk);
      b0.in_valid = 1'b0;
      b0.out_ready = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic reset_midstream();
      int stale = 0;
      @(negedge clk);
      b0.out_ready = 1'b0;
      b0.in_valid = 1'b1;
      b0.in_data = 7'sd9;
      b0.in_offset = '0;
      @(negedge clk);
      b0.in_data = 7'sd10;
      @(negedge clk);
      b0.in_valid = 1'b0;
      chk("inflight_v", int'(b0.out_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_v0", int'(b0.out_valid), 0);
      chk("rst_v1", int'(b1.out_valid), 0);
      chk("rst_cnt", int'(cnt0), 0);
      @(negedge clk);
      rst_n = 1'b1;
      b0.out_ready = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (b0.out_valid || b1.out_valid) stale++;
      end
      chk("no_stale", stale, 0);
      mcnt0 = 0;
      mcnt1 = 0;
   endtask

`ifdef DQNT_DITHER_EN
   task automatic dither();
      int sent = 0, got = 0, cyc = 0, bad = 0;
      longint sum = 0;
      b0.out_ready = 1'b1;
      b0.in_offset = '0;
      b0.in_data = 7'sd5;
      b0.in_valid = 1'b1;
      while (got < 4096 && cyc < 6000) begin
         @(negedge clk);
         cyc++;
         b0.in_valid = sent < 4096;
         #1;
         if (b0.in_valid && b0.in_ready) sent++;
         if (b0.out_valid) begin
            if (int'(b0.out_data) < 36 || int'(b0.out_data) > 43) bad++;
            sum += longint'(int'(b0.out_data));
            got++;
         end
      end
      b0.in_valid = 1'b0;
      chk("dither_count", got, 4096);
      chk("dither_range", bad, 0);
      chk("dither_mean", int'(sum >= 4096 * 393 / 10 && sum <= 4096 * 397 / 10), 1);
   endtask
`endif

   initial begin
      vec_t tbl[12];
      tbl = '{'{5, 0, 40, 44}, '{-64, 0, -512, -508}, '{63, 100, 511, 511}, '{-64, -1, -512, -509},
              '{0, 0, 0, 4}, '{-1, 0, -8, -4}, '{10, -20, 60, 64}, '{63, 7, 511, 511},
              '{63, 8, 511, 511}, '{-1, 511, 503, 507}, '{0, -512, -512, -508}, '{-64, -512, -512, -512}};
      b0.in_valid = 1'b0;
      b0.in_data = '0;
      b0.in_offset = '0;
      b0.out_ready = 1'b0;
      #12;
      chk("reset_v", int'(b0.out_valid), 0);
      chk("reset_d", int'(b0.out_data), 0);
      chk("reset_cnt", int'(cnt0), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", int'(b0.in_ready), 1);
`ifdef DQNT_DITHER_EN
      dither();
`else
      for (int i = 0; i < 12; i++) one(tbl[i].d, tbl[i].off, tbl[i].e0, tbl[i].e1, $sformatf("vec%0d", i));
      @(negedge clk);
      b0.in_valid = 1'b1;
      b0.in_data = 7'sd63;
      b0.in_offset = 10'sd100;
      @(negedge clk);
      b0.in_valid = 1'b0;
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_wins_v", int'(b0.out_valid), 1);
      chk("clr_wins_d", int'(b0.out_data), 511);
      chk("clr_wins_cnt0", int'(cnt0), 0);
      chk("clr_wins_cnt1", int'(cnt1), 0);
      mcnt0 = 0;
      mcnt1 = 0;
      for (int i = 0; i < 10; i++) one(63, 100, 511, 511, "sticky");
      stream(20, 1'b1, 3);
      stream(200, 1'b0, int'($urandom_range(0, 200)) - 100);
      stream(200, 1'b0, int'($urandom_range(0, 1023)) - 512);
      reset_midstream();
      one(5, 0, 40, 44, "post_rst");
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
